// File: rtl/arm_seq_ctrl.sv
// Multi-cycle fetch/exec/mem sequencer with ack timeout fault.
// Optional perf counters enabled by defining ARM_SEQ_PERF_EN.
module arm_seq_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ack,
  input  logic [31:0]       inst_rdata,
  output logic [31:0]       ir,
  input  logic              dec_cond_pass,
  input  logic              dec_load,
  input  logic              dec_store,
  input  logic              dec_branch,
  input  logic [ADDR_W-1:0] dec_target,
  input  logic              dec_halt,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              wb_en,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
`ifdef ARM_SEQ_PERF_EN
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       ret_cnt,
`endif
  output logic              fault
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] AMASK =
    {{(ADDR_W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    FETCH, EXEC, MEM, HALT
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q;
  logic [CW-1:0]     cnt_q;
  logic              fault_q;

  logic [ADDR_W-1:0] pc_inc;
  logic              cnt_exp;
  logic              is_mem;

  assign pc_inc  = pc_q + ADDR_W'(4);
  assign cnt_exp = (cnt_q == CW'(TIMEOUT - 1));
  assign is_mem  = dec_load | dec_store;

  assign inst_req  = (state_q == FETCH);
  assign inst_addr = pc_q;
  assign mem_req   = (state_q == MEM);
  assign mem_we    = (state_q == MEM) & dec_store;
  assign ir        = ir_q;
  assign pc        = pc_q;
  assign halted    = (state_q == HALT);
  assign fault     = fault_q;

  // Commit strobe: plain ALU/branch in EXEC, or load on its ack.
  assign wb_en =
    ((state_q == EXEC) & dec_cond_pass & ~dec_halt & ~is_mem) |
    ((state_q == MEM) & mem_ack & dec_load);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC & AMASK;
      ir_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (inst_ack) begin
            ir_q    <= inst_rdata;
            state_q <= EXEC;
          end else if (cnt_exp) begin
            state_q <= HALT;
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        EXEC: begin
          cnt_q <= '0;
          if (!dec_cond_pass) begin
            pc_q    <= pc_inc;
            state_q <= FETCH;
          end else if (dec_halt) begin
            state_q <= HALT;
          end else if (is_mem) begin
            state_q <= MEM;
          end else begin
            pc_q    <= dec_branch ? (dec_target & AMASK)
                                  : pc_inc;
            state_q <= FETCH;
          end
        end
        MEM: begin
          if (mem_ack) begin
            pc_q    <= pc_inc;
            cnt_q   <= '0;
            state_q <= FETCH;
          end else if (cnt_exp) begin
            state_q <= HALT;
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: state_q <= HALT;
      endcase
    end
  end

`ifdef ARM_SEQ_PERF_EN
  logic [31:0] cyc_q;
  logic [31:0] ret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state_q != HALT) cyc_q <= cyc_q + 32'd1;
      if (state_q == EXEC) ret_q <= ret_q + 32'd1;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_arm_seq_ctrl.sv
// Scoreboard bench for arm_seq_ctrl.
// Expected commit/pc results queued per instruction.
module tb_arm_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic [31:0] ir;
  logic        dec_cond_pass = 1'b1;
  logic        dec_load = 1'b0;
  logic        dec_store = 1'b0;
  logic        dec_branch = 1'b0;
  logic [31:0] dec_target = '0;
  logic        dec_halt = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack = 1'b0;
  logic        wb_en;
  logic [31:0] pc;
  logic        halted;
  logic        fault;
`ifdef ARM_SEQ_PERF_EN
  logic [31:0] cyc_cnt;
  logic [31:0] ret_cnt;
`endif

  always #5 clk = ~clk;

  arm_seq_ctrl #(
    .ADDR_W  (32),
    .RESET_PC(32'h100),
    .TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_ack     (inst_ack),
    .inst_rdata   (inst_rdata),
    .ir           (ir),
    .dec_cond_pass(dec_cond_pass),
    .dec_load     (dec_load),
    .dec_store    (dec_store),
    .dec_branch   (dec_branch),
    .dec_target   (dec_target),
    .dec_halt     (dec_halt),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_ack      (mem_ack),
    .wb_en        (wb_en),
    .pc           (pc),
    .halted       (halted),
`ifdef ARM_SEQ_PERF_EN
    .cyc_cnt      (cyc_cnt),
    .ret_cnt      (ret_cnt),
`endif
    .fault        (fault)
  );

  typedef struct packed {
    logic        wbx;
    logic        mem;
    logic        wbm;
    logic [31:0] npc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_m;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    inst_ack = 1'b0;
    mem_ack  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc", pc, 32'h100);
    chk("rst_ir", ir, 32'h0);
    chk("rst_halted", {31'b0, halted}, 0);
    chk("rst_fault", {31'b0, fault}, 0);
    chk("rst_wb", {31'b0, wb_en}, 0);
    chk("rst_mreq", {31'b0, mem_req}, 0);
    pc_m = 32'h100;
  endtask

  task automatic do_instr(input string nm,
                          input bit c, input bit ld,
                          input bit st, input bit br,
                          input logic [31:0] tgt,
                          input bit hl, input int fd,
                          input int md);
    exp_t        e;
    logic [31:0] rd;
    rd    = $urandom;
    e.wbx = c && !hl && !ld && !st;
    e.mem = c && !hl && (ld || st);
    e.wbm = ld;
    if (!c)            e.npc = pc_m + 32'd4;
    else if (hl)       e.npc = pc_m;
    else if (ld || st) e.npc = pc_m + 32'd4;
    else if (br)       e.npc = tgt & 32'hFFFF_FFFC;
    else               e.npc = pc_m + 32'd4;
    exp_q.push_back(e);
    for (int i = 0; i <= fd; i++) begin
      @(negedge clk);
      rst           = 1'b0;
      mem_ack       = 1'b0;
      inst_ack      = (i == fd);
      inst_rdata    = (i == fd) ? rd : ~rd;
      dec_cond_pass = c;
      dec_load      = ld;
      dec_store     = st;
      dec_branch    = br;
      dec_target    = tgt;
      dec_halt      = hl;
      #1;
      chk({nm, "_ireq"}, {31'b0, inst_req}, 1);
      chk({nm, "_fwb"}, {31'b0, wb_en}, 0);
      if (i == fd)
        chk({nm, "_iaddr"}, inst_addr, pc_m);
    end
    @(negedge clk);
    inst_ack = 1'b0;
    #1;
    e = exp_q.pop_front();
    chk({nm, "_ir"}, ir, rd);
    chk({nm, "_xwb"}, {31'b0, wb_en}, {31'b0, e.wbx});
    chk({nm, "_xmreq"}, {31'b0, mem_req}, 0);
    if (e.mem) begin
      for (int i = 0; i <= md; i++) begin
        @(negedge clk);
        mem_ack = (i == md);
        #1;
        chk({nm, "_mreq"}, {31'b0, mem_req}, 1);
        chk({nm, "_mwe"}, {31'b0, mem_we}, {31'b0, st});
        chk({nm, "_mwb"}, {31'b0, wb_en},
            {31'b0, (i == md) && e.wbm});
      end
    end
    pc_m = e.npc;
  endtask

  initial begin
    do_reset();
    do_instr("alu", 1, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_pc", pc_m, 32'h104);
    do_instr("br", 1, 0, 0, 1, 32'h2003, 0, 0, 0);
    do_instr("cfail", 0, 1, 0, 0, 0, 0, 1, 0);
    do_instr("load", 1, 1, 0, 0, 0, 0, 1, 2);
    do_instr("store", 1, 0, 1, 0, 0, 0, 0, 0);
    do_instr("ack4", 1, 0, 0, 0, 0, 0, 3, 0);
    do_instr("brhi", 1, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0);
    do_instr("wrap", 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_iaddr", inst_addr, pc_m);
    // The cycle above was fetch cycle 1; three more withheld.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      inst_ack = 1'b0;
      #1;
      chk("to_ireq", {31'b0, inst_req}, 1);
      chk("to_halt0", {31'b0, halted}, 0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      inst_ack = 1'b1;
      mem_ack  = 1'b1;
      #1;
      chk("to_halted", {31'b0, halted}, 1);
      chk("to_fault", {31'b0, fault}, 1);
      chk("to_ireq0", {31'b0, inst_req}, 0);
      chk("to_pc", pc, 32'h0);
    end

    do_reset();
    do_instr("alu2", 1, 0, 0, 0, 0, 0, 0, 0);
    do_instr("halt", 1, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inst_ack = 1'b1;
      mem_ack  = 1'b1;
      #1;
      chk("h_halted", {31'b0, halted}, 1);
      chk("h_fault", {31'b0, fault}, 0);
      chk("h_ireq", {31'b0, inst_req}, 0);
      chk("h_mreq", {31'b0, mem_req}, 0);
      chk("h_wb", {31'b0, wb_en}, 0);
      chk("h_pc", pc, pc_m);
    end

    do_reset();
    @(negedge clk);
    rst           = 1'b0;
    inst_ack      = 1'b1;
    inst_rdata    = 32'hE591_0000;
    dec_cond_pass = 1'b1;
    dec_load      = 1'b1;
    dec_store     = 1'b0;
    dec_branch    = 1'b0;
    dec_halt      = 1'b0;
    @(negedge clk);
    inst_ack = 1'b0;
    #1;
    chk("rm_ir", ir, 32'hE591_0000);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("rm_mreq", {31'b0, mem_req}, 1);
    @(negedge clk);
    rst     = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rm_mreq0", {31'b0, mem_req}, 0);
    chk("rm_wb", {31'b0, wb_en}, 0);
    chk("rm_pc", pc, 32'h100);
    chk("rm_ireq", {31'b0, inst_req}, 1);
    mem_ack = 1'b0;
    chk("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
